ysyx_2022040010_div: RTL and testbench
======================================

Name: ysyx_2022040010_div

Overview:
Multi-cycle iterative divider for the NPC EXU. It is the inverse-direction companion of the 64-bit adder and uses a shift-subtract (restoring) datapath.
- Serves DIV/DIVU/REM/REMU and the W variants (DIVW/DIVUW/REMW/REMUW).
- Uses a valid/ready handshake toward the EXU pipeline control.
- Result formatting mirrors the adder's alu_32 rule: the low 32 bits of the result are sign-extended to 64.

Parameters:
XLEN, 64, operand/result width; fixed at 64 for RV64.
CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  divider can accept; high only in IDLE
in_a  input  64  dividend
in_b  input  64  divisor
is_signed  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU
alu_32  input  1  1 = W-variant (32-bit operation)
flush  input  1  pipeline flush; abort any operation
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_q  output  64  quotient
out_r  output  64  remainder

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock port is clk; reset port is rst.
- Reset: state=IDLE, out_valid=0, out_q=0, out_r=0, counter=0.
- in_ready = (state==IDLE) && !rst. It is combinational from state.
- States:
  - IDLE: on in_valid && !flush, latch operands and go to CALC.
  - CALC: one quotient bit per cycle for N cycles, with N=32 when alu_32 else 64; then go to DONE.
  - DONE: out_valid=1; outputs held stable until out_ready, then go to IDLE.
- Operand prep at accept:
  - alu_32=1: use in_a[31:0] and in_b[31:0], sign-extended if is_signed, else zero-extended.
  - is_signed=1: divide absolute values; record sign_q = sign(a) XOR sign(b) and sign_r = sign(a).
- Each iteration: rem = {rem, next dividend bit}. If rem >= divisor, then rem -= divisor and the q bit is 1.
- Finalize on the CALC->DONE transition:
  - Negate quotient if sign_q; negate remainder if sign_r.
  - If alu_32=1, sign-extend bit 31 of both results to 64 bits. This applies to DIVUW/REMUW too.
- Latency from accept edge to out_valid high: N+1 cycles, i.e. 33 (W) or 65. Throughput: one op per N+2 cycles minimum.
- RISC-V special cases, forced at finalize regardless of algorithm result:
  - divisor==0: q = all ones (after W sign-extension: 0xFFFF_FFFF_FFFF_FFFF), r = dividend (W: sign-extended low 32).
  - Signed overflow (a = most negative for the width, b = -1): q = a, r = 0.
- flush: in any state, next state is IDLE and out_valid drops next cycle; in-flight result is discarded. flush in IDLE with in_valid means no accept.
- out_valid && out_ready in the same cycle as in_valid: the new op is not accepted that cycle because in_ready is still low. It is accepted the following cycle.
- rst mid-CALC or mid-DONE: immediate return to reset values; no result emitted.
- Operand inputs may change after accept without effect.

Optional Feature:
Macro YSYX_2022040010_DIV_EARLY_EN.
- Defined: divisor==0 and signed-overflow cases bypass CALC. IDLE goes directly to DONE with the special-case results, so out_valid is high 1 cycle after accept.
- Undefined: these cases iterate the full N cycles and are patched at finalize. Results are identical; only latency differs.

Decomposition:
- Shared package ysyx_2022040010_pkg holds:
  - state enum DIV_IDLE/DIV_CALC/DIV_DONE;
  - constants XLEN=64 and DIV_ITER_64=64, DIV_ITER_32=32;
  - localparams for the all-ones quotient and the most-negative values.
- One natural sub-module, ysyx_2022040010_div_prep. It is combinational and handles abs/extend of operands, sign flags, and special-case detection. The FSM, counter, and shift-subtract datapath stay in the top module.

Test Plan:
- DIVU 64-bit: a=100, b=7, out_ready=1 -> out_valid 65 cycles after accept; q=14, r=2.
- DIV signed: a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 -> q=-3 (0x...FFFD), r=-1 (0x...FFFF). DIVW: a=0x0000_0001_8000_0000, b=0x1 -> q=0xFFFF_FFFF_8000_0000, r=0, latency 33.
- Divide by zero: DIVU a=0x1234, b=0 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0x1234. Latency is 1 cycle with YSYX_2022040010_DIV_EARLY_EN, 65 without.
- Overflow: DIV a=0x8000_0000_0000_0000, b=-1 -> q=0x8000_0000_0000_0000, r=0. DIVW a=0x8000_0000, b=0xFFFF_FFFF -> q=0xFFFF_FFFF_8000_0000, r=0.
- Backpressure/flush:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_q, out_r stable and in_ready=0.
  - Assert flush at CALC cycle 20 -> out_valid never rises, in_ready=1 next cycle, and the next op completes correctly.
- Reset: assert rst mid-CALC -> next cycle out_valid=0, out_q=0, out_r=0, in_ready=1 once rst deasserts.

Source files
------------

// File: rtl/ysyx_2022040010_pkg.sv
// Shared types, constants and result-formatting helper for the NPC iterative divider.
package ysyx_2022040010_pkg;

    localparam int XLEN        = 64;
    localparam int CNT_W       = 7;
    localparam int DIV_ITER_64 = 64;
    localparam int DIV_ITER_32 = 32;

    localparam logic [XLEN-1:0] DIV_ONES   = '1;
    localparam logic [XLEN-1:0] DIV_MIN_64 = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] DIV_MIN_32 = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
    } div_res_t;

    // Applies signs, RISC-V special-case overrides, then the W-variant sign-extension.
    function automatic div_res_t div_finalize(
        input logic [XLEN-1:0] q_mag,
        input logic [XLEN-1:0] r_mag,
        input logic            sign_q,
        input logic            sign_r,
        input logic            w,
        input logic            div0,
        input logic            ovf,
        input logic [XLEN-1:0] a_ext
    );
        div_res_t res;
        res.q = sign_q ? -q_mag : q_mag;
        res.r = sign_r ? -r_mag : r_mag;
        if (div0) begin
            res.q = DIV_ONES;
            res.r = a_ext;
        end else if (ovf) begin
            res.q = a_ext;
            res.r = '0;
        end
        if (w) begin
            res.q = {{32{res.q[31]}}, res.q[31:0]};
            res.r = {{32{res.r[31]}}, res.r[31:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_div_prep.sv
// Combinational operand preparation: width extension, magnitudes, result signs
// and detection of the divide-by-zero / signed-overflow cases.
module ysyx_2022040010_div_prep
    import ysyx_2022040010_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            is_signed_i,
    input  logic            alu_32_i,
    output logic [XLEN-1:0] a_ext_o,
    output logic [XLEN-1:0] abs_a_o,
    output logic [XLEN-1:0] abs_b_o,
    output logic            sign_q_o,
    output logic            sign_r_o,
    output logic            div0_o,
    output logic            ovf_o
);

    logic [XLEN-1:0] b_ext;
    logic            neg_a;
    logic            neg_b;

    always_comb begin
        a_ext_o = a_i;
        b_ext   = b_i;
        if (alu_32_i) begin
            a_ext_o = is_signed_i ? {{32{a_i[31]}}, a_i[31:0]} : {32'b0, a_i[31:0]};
            b_ext   = is_signed_i ? {{32{b_i[31]}}, b_i[31:0]} : {32'b0, b_i[31:0]};
        end
    end

    assign neg_a    = is_signed_i & a_ext_o[XLEN-1];
    assign neg_b    = is_signed_i & b_ext[XLEN-1];
    assign abs_a_o  = neg_a ? -a_ext_o : a_ext_o;
    assign abs_b_o  = neg_b ? -b_ext : b_ext;
    assign sign_q_o = neg_a ^ neg_b;
    assign sign_r_o = neg_a;

    assign div0_o = (b_ext == '0);
    assign ovf_o  = is_signed_i && (b_ext == DIV_ONES)
                 && (a_ext_o == (alu_32_i ? DIV_MIN_32 : DIV_MIN_64));

endmodule

// File: rtl/ysyx_2022040010_div.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU and W variants.
// Define YSYX_2022040010_DIV_EARLY_EN to complete divide-by-zero/overflow without iterating.
module ysyx_2022040010_div
    import ysyx_2022040010_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            is_signed,
    input  logic            alu_32,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_q,
    output logic [XLEN-1:0] out_r
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] dvd_q, dvd_d, rem_q, rem_d, dsr_q, dsr_d;
    logic [XLEN-1:0] a_ext_q, a_ext_d, q_res_q, q_res_d, r_res_q, r_res_d;
    logic            sign_q_q, sign_q_d, sign_r_q, sign_r_d;
    logic            w_q, w_d, div0_q, div0_d, ovf_q, ovf_d;

    logic [XLEN-1:0] p_a_ext, p_abs_a, p_abs_b;
    logic            p_sign_q, p_sign_r, p_div0, p_ovf;

    ysyx_2022040010_div_prep u_prep (
        .a_i         (in_a),
        .b_i         (in_b),
        .is_signed_i (is_signed),
        .alu_32_i    (alu_32),
        .a_ext_o     (p_a_ext),
        .abs_a_o     (p_abs_a),
        .abs_b_o     (p_abs_b),
        .sign_q_o    (p_sign_q),
        .sign_r_o    (p_sign_r),
        .div0_o      (p_div0),
        .ovf_o       (p_ovf)
    );

    // The dividend register shifts out its MSB into the remainder while quotient
    // bits shift in at the bottom; W operands are pre-aligned to the top half.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff, rem_step, dvd_step;
    logic            ge, last_iter;
    div_res_t        fin;

    assign trial     = {rem_q, dvd_q[XLEN-1]};
    assign ge        = (trial >= {1'b0, dsr_q});
    assign diff      = trial[XLEN-1:0] - dsr_q;
    assign rem_step  = ge ? diff : trial[XLEN-1:0];
    assign dvd_step  = {dvd_q[XLEN-2:0], ge};
    assign last_iter = (cnt_q == (w_q ? CNT_W'(DIV_ITER_32 - 1) : CNT_W'(DIV_ITER_64 - 1)));
    assign fin       = div_finalize(dvd_step, rem_step, sign_q_q, sign_r_q, w_q,
                                    div0_q, ovf_q, a_ext_q);

`ifdef YSYX_2022040010_DIV_EARLY_EN
    div_res_t early_fin;
    assign early_fin = div_finalize('0, '0, 1'b0, 1'b0, alu_32, p_div0, p_ovf, p_a_ext);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        a_ext_d  = a_ext_q;
        q_res_d  = q_res_q;
        r_res_d  = r_res_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        w_d      = w_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        case (state_q)
            DIV_IDLE: begin
                if (in_valid && !flush) begin
                    state_d  = DIV_CALC;
                    cnt_d    = '0;
                    rem_d    = '0;
                    dvd_d    = alu_32 ? {p_abs_a[31:0], 32'b0} : p_abs_a;
                    dsr_d    = p_abs_b;
                    a_ext_d  = p_a_ext;
                    sign_q_d = p_sign_q;
                    sign_r_d = p_sign_r;
                    w_d      = alu_32;
                    div0_d   = p_div0;
                    ovf_d    = p_ovf;
`ifdef YSYX_2022040010_DIV_EARLY_EN
                    if (p_div0 || p_ovf) begin
                        state_d = DIV_DONE;
                        q_res_d = early_fin.q;
                        r_res_d = early_fin.r;
                    end
`endif
                end
            end
            DIV_CALC: begin
                rem_d = rem_step;
                dvd_d = dvd_step;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = DIV_DONE;
                    q_res_d = fin.q;
                    r_res_d = fin.r;
                end
            end
            DIV_DONE: begin
                if (out_ready) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            a_ext_q  <= '0;
            q_res_q  <= '0;
            r_res_q  <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            w_q      <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            a_ext_q  <= a_ext_d;
            q_res_q  <= q_res_d;
            r_res_q  <= r_res_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            w_q      <= w_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == DIV_IDLE) && !rst;
    assign out_valid = (state_q == DIV_DONE);
    assign out_q     = q_res_q;
    assign out_r     = r_res_q;

endmodule

// File: tb/tb_ysyx_2022040010_div.sv
// Self-checking bench for ysyx_2022040010_div: directed RISC-V cases, random ops
// against a reference model, backpressure, flush and mid-operation reset.
module tb_ysyx_2022040010_div;

`ifdef YSYX_2022040010_DIV_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, is_signed, alu_32, flush;
    logic        out_valid, out_ready;
    logic [63:0] in_a, in_b, out_q, out_r;

    logic [63:0] exp_q[$];
    logic [63:0] exp_r[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .is_signed (is_signed),
        .alu_32    (alu_32),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
        end
    endtask

    // Reference semantics written directly from the RISC-V definition.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1;
                r = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a;
                r = 64'd0;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b,
                                   input logic s, input logic w);
        logic sp;
        if (w) sp = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   sp = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
        if (sp && EARLY) return 1;
        return w ? 33 : 65;
    endfunction

    // Presents an operation, waits for acceptance, then scrambles the inputs.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
        int guard = 0;
        @(negedge clk);
        in_a = a; in_b = b; is_signed = s; alu_32 = w; in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = {$urandom, $urandom};
        in_b      = {$urandom, $urandom};
        is_signed = 1'($urandom_range(0, 1));
        alu_32    = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                          input logic [63:0] q_exp, input logic [63:0] r_exp,
                          input int hold, input string tag);
        int          lat;
        logic [63:0] eq, er;
        exp_q.push_back(q_exp);
        exp_r.push_back(r_exp);
        out_ready = (hold == 0);
        send(a, b, s, w);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b, s, w)));
        eq = exp_q.pop_front();
        er = exp_r.pop_front();
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, {63'b0, out_valid}, 64'd1);
            check({tag, "_hold_ready"}, {63'b0, in_ready}, 64'd0);
            check({tag, "_hold_q"}, out_q, eq);
            check({tag, "_hold_r"}, out_r, er);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check({tag, "_q"}, out_q, eq);
        check({tag, "_r"}, out_r, er);
        @(negedge clk);
        check({tag, "_valid_drop"}, {63'b0, out_valid}, 64'd0);
        check({tag, "_ready_back"}, {63'b0, in_ready}, 64'd1);
    endtask

    task automatic run_model(input logic [63:0] a, input logic [63:0] b, input logic s,
                             input logic w, input string tag);
        logic [63:0] q, r;
        model(a, b, s, w, q, r);
        run_op(a, b, s, w, q, r, 0, tag);
    endtask

    initial begin
        int          seen;
        logic [63:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; is_signed = 1'b0; alu_32 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_q", out_q, 64'd0);
        check("rst_out_r", out_r, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 0, "divu");
        run_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 0, "div_neg");
        run_op(64'h0000_0001_8000_0000, 64'd1, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 0, "divw");
        run_op(64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 0, "div0");
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h8000_0000_0000_0000, 64'd0, 0, "ovf");
        run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 0, "ovfw");
        run_op(64'h8000_1234, 64'd0, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_1234, 0, "div0uw");
        run_op(64'hF000_0000, 64'd1, 1'b0, 1'b1,
               64'hFFFF_FFFF_F000_0000, 64'd0, 0, "divuw_sext");
        run_op(64'd1000, 64'd33, 1'b0, 1'b0, 64'd30, 64'd10, 10, "bp");

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(1, 200)) : {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_model(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        // Flush twenty cycles into CALC: the result must never appear.
        out_ready = 1'b1;
        send(64'd5000, 64'd3, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", {63'b0, out_valid}, 64'd0);
        check("flush_ready", {63'b0, in_ready}, 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        run_model(64'd5000, 64'd3, 1'b0, 1'b0, "after_flush");

        // Flush together with a request in IDLE must not accept it.
        @(negedge clk);
        in_a = 64'd9; in_b = 64'd2; is_signed = 1'b0; alu_32 = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_ready", {63'b0, in_ready}, 64'd1);

        // Reset mid-CALC clears the held result from the previous operation.
        send(64'hFFFF_0000_1234_5678, 64'd77, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_q", out_q, 64'd0);
        check("midrst_r", out_r, 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_ready", {63'b0, in_ready}, 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        run_model(64'hFFFF_FFFF_FFFF_FF00, 64'd10, 1'b1, 1'b0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
